rom_burst_reader: RTL

Burst read initiator for the team's combinational ROM read port (address / read_en / ce / data). On a start command it walks a contiguous address range, drives the ROM strobes one word at a time, captures each returned word, and presents it on a valid/ready output stream with backpressure. It sits between the ROM instance and any consumer that needs table contents streamed out, such as a pattern player or a configuration loader.

---
 rtl/rom_burst_reader_pkg.sv | 13 +
 rtl/rom_burst_reader.sv | 107 ++++++++++
 2 files changed

// File: rtl/rom_burst_reader_pkg.sv
// Shared types and default widths for the ROM burst reader.
package rom_burst_reader_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/rom_burst_reader.sv
// Streams a contiguous ROM address range out on a valid/ready port, one word per READ/HOLD pair.
// Latency: first word valid 2 cycles after start; one word per 2 cycles at full rate.
// Backpressure: HOLD parks with strobes low and data/last stable until out_ready; abort wins over all.
module rom_burst_reader
   import rom_burst_reader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] count_m1,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ce,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] remaining;
   logic              load, capture, advance, finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      capture  = 1'b0;
      advance  = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nx = READ;
               load     = 1'b1;
            end
         end
         READ: begin
            if (abort) begin
               state_nx = IDLE;
            end else begin
               state_nx = HOLD;
               capture  = 1'b1;
            end
         end
         HOLD: begin
            // A handshake coinciding with abort is dropped, not completed.
            if (abort) begin
               state_nx = IDLE;
            end else if (out_ready) begin
               if (remaining == '0) begin
                  state_nx = IDLE;
                  finish   = 1'b1;
               end else begin
                  state_nx = READ;
                  advance  = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            mem_addr  <= base;
            remaining <= count_m1;
         end else if (advance) begin
            mem_addr  <= mem_addr + 1'b1;
            remaining <= remaining - 1'b1;
         end
         if (capture) begin
            out_data <= mem_data;
            out_last <= (remaining == '0);
         end else if (state_nx != HOLD) begin
            out_last <= 1'b0;
         end
      end
   end

   // Strobes and status decode straight from the state flops.
   assign mem_ce    = (state == READ);
   assign mem_rd_en = mem_ce;
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);

endmodule
